// File: rtl/trap_ctrl.sv
// Machine-interrupt / mret sequencer: drains the pipeline, pulses the csr_reg trap inputs
// and redirects fetch to the trap vector or to mepc.
module trap_ctrl #(
    parameter int unsigned VECTORED_EN = 1,
    parameter int unsigned RET_HOLDOFF = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic        MIE,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        mret_valid,
    input  logic        pipe_ready,
    input  logic [31:0] pipe_pc,
    output logic        flush,
    output logic        int_action,
    output logic        ret_action,
    output logic        hw_int,
    output logic [4:0]  int_code,
    output logic [31:0] current_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    // state | meaning
    // IDLE  | waiting for an eligible interrupt or an mret
    // DRAIN | flushing, waiting for pipe_ready; aborts if the source goes away
    // TAKE  | one-cycle interrupt pulse and redirect to the trap vector
    // RET   | one-cycle mret pulse and redirect to mepc
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TAKE, S_RET} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_code;
    logic [31:0] r_pc;
    logic [3:0]  r_holdoff;

    logic [31:0] w_elig;
    logic        w_any;
    logic [4:0]  w_code;
    logic        w_still;
    logic [3:0]  w_hold_nxt;
    logic [31:0] w_base;

    logic        w_flush_nxt;
    logic        w_int_nxt;
    logic        w_ret_nxt;
    logic [4:0]  w_code_nxt;
    logic        w_redirect_nxt;
    logic        w_busy_nxt;

    assign w_elig  = mip & mie & {32{MIE}};
    assign w_any   = w_elig[11] | w_elig[3] | w_elig[7];
    assign w_still = w_elig[r_code];
    assign w_base  = {mtvec[31:2], 2'b00};

    always_comb begin
        w_code = 5'd0;
        if (w_elig[11])
            w_code = 5'd11;
        else if (w_elig[3])
            w_code = 5'd3;
        else if (w_elig[7])
            w_code = 5'd7;
    end

    always_comb begin
        w_hold_nxt = 4'd0;
        if (r_state == S_RET)
            w_hold_nxt = 4'(RET_HOLDOFF);
        else if (r_holdoff != 4'd0)
            w_hold_nxt = r_holdoff - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_code    <= 5'd0;
            r_pc      <= 32'd0;
            r_holdoff <= 4'd0;
        end else begin
            r_state   <= w_next;
            r_holdoff <= w_hold_nxt;
            if (r_state == S_IDLE && w_next == S_DRAIN)
                r_code <= w_code;
            if (r_state == S_DRAIN && w_next == S_TAKE)
                r_pc <= pipe_pc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any && r_holdoff == 4'd0)
                    w_next = S_DRAIN;
                else if (mret_valid)
                    w_next = S_RET;
            end
            S_DRAIN: begin
                if (!w_still)
                    w_next = S_IDLE;
                else if (pipe_ready)
                    w_next = S_TAKE;
            end
            S_TAKE:  w_next = S_IDLE;
            S_RET:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        w_flush_nxt    = (w_next != S_IDLE);
        w_int_nxt      = (w_next == S_TAKE);
        w_ret_nxt      = (w_next == S_RET);
        w_code_nxt     = (w_next == S_TAKE) ? r_code : 5'd0;
        w_redirect_nxt = (w_next == S_TAKE) || (w_next == S_RET);
        w_busy_nxt     = (w_next != S_IDLE) || (w_hold_nxt != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush      <= 1'b0;
            int_action <= 1'b0;
            ret_action <= 1'b0;
            hw_int     <= 1'b0;
            int_code   <= 5'd0;
            redirect   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            flush      <= w_flush_nxt;
            int_action <= w_int_nxt;
            ret_action <= w_ret_nxt;
            hw_int     <= w_int_nxt;
            int_code   <= w_code_nxt;
            redirect   <= w_redirect_nxt;
            busy       <= w_busy_nxt;
        end
    end

    assign current_pc = r_pc;

    always_comb begin
        redirect_pc = w_base;
        if (r_state == S_RET)
            redirect_pc = mepc;
        else if (VECTORED_EN != 0 && mtvec[1:0] == 2'b01)
            redirect_pc = w_base + {25'd0, r_code, 2'b00};
    end
endmodule
